// File: rtl/ahb_vga_write_master.sv
// AHB-Lite single-word write initiator feeding the VGA console/image regions from a byte-command FIFO.
// Build option: define VGA_IMG_AUTOINC_EN to replace cmd_offset with an internal auto-incrementing image pointer.
//
// bus_state | meaning
// BUS_OK    | normal pipelined operation, AP drives NONSEQ when loaded
// BUS_ERR   | second cycle of an ERROR response, AP held but bus forced IDLE
module ahb_vga_write_master #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] CONSOLE_ADDR = 32'h5000_0000,
  parameter logic [31:0] IMAGE_BASE   = 32'h5000_0000,
  parameter int unsigned IMG_WORDS    = 16384
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_image,
  input  logic [13:0] cmd_offset,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic        done,
  output logic        err_sticky,
  input  logic        err_clr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic        image;
    logic [13:0] offset;
    logic [7:0]  data;
  } cmd_t;

  typedef enum logic {BUS_OK, BUS_ERR} bus_state_t;

  cmd_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rdy_q;

  bus_state_t    state_q, state_d;
  logic          ap_valid_q, ap_valid_d;
  logic [31:0]   ap_addr_q, ap_addr_d;
  logic [7:0]    ap_data_q, ap_data_d;
  logic          dp_valid_q, dp_valid_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;

  logic          full, empty, push_hs, illegal, push, pop, nonseq;
  cmd_t          head;
  logic [31:0]   img_addr, load_addr;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign cmd_ready = rdy_q & ~full;
  assign push_hs   = cmd_valid & cmd_ready;
  assign push      = push_hs & ~illegal;
  assign head      = fifo_q[rd_ptr_q];
  assign nonseq    = ap_valid_q & (state_q == BUS_OK);
  // AP refills when empty, or when its NONSEQ is accepted this edge
  assign pop       = ~empty & (~ap_valid_q | (nonseq & HREADY));

`ifdef VGA_IMG_AUTOINC_EN
  localparam logic [13:0] PTR_LAST = 14'(IMG_WORDS - 1);
  logic [13:0] img_ptr_q, img_ptr_d;

  assign illegal  = 1'b0;
  assign img_addr = IMAGE_BASE | {16'h0, img_ptr_q, 2'b00};

  always_comb begin
    img_ptr_d = img_ptr_q;
    if (pop && head.image)
      img_ptr_d = (img_ptr_q == PTR_LAST) ? 14'd1 : img_ptr_q + 14'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) img_ptr_q <= 14'd1;
    else          img_ptr_q <= img_ptr_d;
  end
`else
  // offset 0 would alias the console, so it is swallowed at the handshake
  assign illegal  = cmd_image & (cmd_offset == 14'd0);
  assign img_addr = IMAGE_BASE | {16'h0, head.offset, 2'b00};
`endif

  assign load_addr = head.image ? img_addr : CONSOLE_ADDR;

  always_ff @(posedge HCLK) begin
    if (push) fifo_q[wr_ptr_q] <= '{image: cmd_image, offset: cmd_offset, data: cmd_data};
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ap_valid_d = ap_valid_q;
    ap_addr_d  = ap_addr_q;
    ap_data_d  = ap_data_q;
    dp_valid_d = dp_valid_q;
    hwdata_d   = hwdata_q;
    done_d     = 1'b0;
    drop_d     = push_hs & illegal;
    err_d      = err_q & ~err_clr;

    case (state_q)
      BUS_OK:  if (dp_valid_q && HRESP && !HREADY) state_d = BUS_ERR;
      BUS_ERR: if (HREADY) state_d = BUS_OK;
      default: state_d = BUS_OK;
    endcase

    if (HREADY) begin
      if (dp_valid_q) begin
        if (HRESP) drop_d = 1'b1;
        else       done_d = 1'b1;
      end
      dp_valid_d = nonseq;
      if (nonseq) begin
        hwdata_d   = {24'h0, ap_data_q};
        ap_valid_d = 1'b0;
      end
    end

    if (pop) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = load_addr;
      ap_data_d  = head.data;
    end

    if ((push_hs && illegal) || (HREADY && dp_valid_q && HRESP)) err_d = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rdy_q      <= 1'b0;
      state_q    <= BUS_OK;
      ap_valid_q <= 1'b0;
      ap_addr_q  <= '0;
      ap_data_q  <= '0;
      dp_valid_q <= 1'b0;
      hwdata_q   <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q    <= count_d;
      rdy_q      <= 1'b1;
      state_q    <= state_d;
      ap_valid_q <= ap_valid_d;
      ap_addr_q  <= ap_addr_d;
      ap_data_q  <= ap_data_d;
      dp_valid_q <= dp_valid_d;
      hwdata_q   <= hwdata_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  assign HADDR      = ap_addr_q;
  assign HTRANS     = nonseq ? 2'b10 : 2'b00;
  assign HWRITE     = nonseq;
  assign HSIZE      = 3'b010;
  assign HBURST     = 3'b000;
  assign HPROT      = 4'b0011;
  assign HMASTLOCK  = 1'b0;
  assign HWDATA     = hwdata_q;
  assign done       = done_q;
  assign err_sticky = err_q;
  // done/drop pulses keep busy up for the completion cycle
  assign busy       = ~empty | ap_valid_q | dp_valid_q | done_q | drop_q;

endmodule

// File: tb/tb_ahb_vga_write_master.sv
// Directed self-checking bench for ahb_vga_write_master; honours VGA_IMG_AUTOINC_EN when defined.
module tb_ahb_vga_write_master;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_image;
  logic [7:0]  cmd_data;
  logic [13:0] cmd_offset;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        busy, done, err_sticky, err_clr;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [13:0] exp_ptr = 14'd1;

  ahb_vga_write_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_image(cmd_image), .cmd_offset(cmd_offset),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .done(done), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) if (done === 1'b1) done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  function automatic logic [31:0] img_exp(input logic [13:0] off);
`ifdef VGA_IMG_AUTOINC_EN
    img_exp = 32'h5000_0000 | {16'h0, exp_ptr, 2'b00};
    exp_ptr = (exp_ptr == 14'd16383) ? 14'd1 : exp_ptr + 14'd1;
`else
    img_exp = 32'h5000_0000 | {16'h0, off, 2'b00};
`endif
  endfunction

  task automatic drive_cmd(input logic v, input logic img, input logic [13:0] off, input logic [7:0] d);
    cmd_valid = v; cmd_image = img; cmd_offset = off; cmd_data = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge HCLK); n++; end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL wait_idle busy=%b required 0 after 100 cycles", busy); end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HREADY = 1'b1; HRESP = 1'b0; err_clr = 1'b0;
    drive_cmd(0, 0, 14'd0, 8'h00);
    repeat (3) @(negedge HCLK);
    tests++;
    if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
      fails++; $display("FAIL reset_bus HTRANS=%h HADDR=%h HWRITE=%b HWDATA=%h required 0/0/0/0", HTRANS, HADDR, HWRITE, HWDATA);
    end
    tests++;
    if ({done, busy, err_sticky, cmd_ready} !== 4'b0000) begin
      fails++; $display("FAIL reset_status done/busy/err/ready=%b required 0000", {done, busy, err_sticky, cmd_ready});
    end
    tests++;
    if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      fails++; $display("FAIL reset_consts HSIZE=%h HBURST=%h HPROT=%h HMASTLOCK=%b", HSIZE, HBURST, HPROT, HMASTLOCK);
    end
    HRESETn = 1'b1;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge got=%b required 0", cmd_ready); end
    @(negedge HCLK);
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got=%b required 1", cmd_ready); end
  endtask

  task automatic test_console();
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL console_ready got=%b required 1", cmd_ready); end
    drive_cmd(1, 0, 14'd0, 8'h41);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (HTRANS !== 2'b00 || busy !== 1'b1) begin
      fails++; $display("FAIL console_e0 HTRANS=%h busy=%b required 0/1", HTRANS, busy);
    end
    @(negedge HCLK);
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h5000_0000 || HWRITE !== 1'b1) begin
      fails++; $display("FAIL console_addr HTRANS=%h HADDR=%h HWRITE=%b required 2/50000000/1", HTRANS, HADDR, HWRITE);
    end
    @(negedge HCLK);
    tests++;
    if (HWDATA !== 32'h41 || HTRANS !== 2'b00 || done !== 1'b0) begin
      fails++; $display("FAIL console_data HWDATA=%h HTRANS=%h done=%b required 41/0/0", HWDATA, HTRANS, done);
    end
    @(negedge HCLK);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL console_done got=%b required 1", done); end
    @(negedge HCLK);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL console_end done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a [4];
    exp_a[0] = img_exp(14'd1);
    drive_cmd(1, 1, 14'd1, 8'h10);
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (i + 1 < 4) begin
        exp_a[i+1] = img_exp(14'(i + 2));
        drive_cmd(1, 1, 14'(i + 2), 8'(8'h10 + i + 1));
      end else drive_cmd(0, 0, 14'd0, 8'h00);
      tests++;
      if (i >= 1 && i <= 4) begin
        if (HTRANS !== 2'b10 || HADDR !== exp_a[i-1]) begin
          fails++; $display("FAIL b2b_addr[%0d] HTRANS=%h HADDR=%h required 2/%h", i, HTRANS, HADDR, exp_a[i-1]);
        end
      end else if (HTRANS !== 2'b00) begin
        fails++; $display("FAIL b2b_idle[%0d] HTRANS=%h required 0", i, HTRANS);
      end
      if (i >= 2 && i <= 5) begin
        tests++;
        if (HWDATA !== 32'(8'h10 + i - 2)) begin
          fails++; $display("FAIL b2b_data[%0d] HWDATA=%h required %h", i, HWDATA, 8'h10 + i - 2);
        end
      end
      tests++;
      if (done !== ((i >= 3 && i <= 6) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL b2b_done[%0d] done=%b", i, done);
      end
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy got=%b required 0", busy); end
  endtask

  task automatic test_wait_states();
    logic [31:0] exp2;
    drive_cmd(1, 0, 14'd0, 8'h55);
    @(negedge HCLK);
    exp2 = img_exp(14'd5);
    drive_cmd(1, 1, 14'd5, 8'h66);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h5000_0000) begin
      fails++; $display("FAIL ws_first HTRANS=%h HADDR=%h required 2/50000000", HTRANS, HADDR);
    end
    @(negedge HCLK);
    HREADY = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tests++;
      if (HTRANS !== 2'b10 || HADDR !== exp2 || HWDATA !== 32'h55 || done !== 1'b0) begin
        fails++; $display("FAIL ws_stall[%0d] HTRANS=%h HADDR=%h HWDATA=%h done=%b required 2/%h/55/0", j, HTRANS, HADDR, HWDATA, done, exp2);
      end
      @(negedge HCLK);
      if (j == 4) HREADY = 1'b1;
    end
    tests++;
    if (HWDATA !== 32'h66 || HTRANS !== 2'b00 || done !== 1'b1) begin
      fails++; $display("FAIL ws_release HWDATA=%h HTRANS=%h done=%b required 66/0/1", HWDATA, HTRANS, done);
    end
    @(negedge HCLK);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL ws_done2 got=%b required 1", done); end
    @(negedge HCLK);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL ws_end done=%b busy=%b required 0/0", done, busy);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] exp_f [5];
    HREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (cmd_ready !== 1'b1) begin fails++; $display("FAIL full_ready[%0d] got=%b required 1", i, cmd_ready); end
      exp_f[i] = img_exp(14'(i + 1));
      drive_cmd(1, 1, 14'(i + 1), 8'(8'hA0 + i));
      @(negedge HCLK);
    end
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_notready got=%b required 0", cmd_ready); end
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== exp_f[0]) begin
      fails++; $display("FAIL full_head HTRANS=%h HADDR=%h required 2/%h", HTRANS, HADDR, exp_f[0]);
    end
    HREADY = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge HCLK);
      if (k <= 5) begin
        tests++;
        if (HWDATA !== 32'(8'hA0 + k - 1)) begin
          fails++; $display("FAIL full_data[%0d] HWDATA=%h required %h", k, HWDATA, 8'hA0 + k - 1);
        end
      end
      if (k <= 4) begin
        tests++;
        if (HTRANS !== 2'b10 || HADDR !== exp_f[k]) begin
          fails++; $display("FAIL full_addr[%0d] HTRANS=%h HADDR=%h required 2/%h", k, HTRANS, HADDR, exp_f[k]);
        end
      end
      tests++;
      if (done !== ((k >= 2 && k <= 6) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL full_done[%0d] done=%b", k, done);
      end
    end
  endtask

  task automatic test_error();
    logic [31:0] expA, expB;
    int d0 = done_cnt;
    expA = img_exp(14'd6);
    drive_cmd(1, 1, 14'd6, 8'hC1);
    @(negedge HCLK);
    expB = img_exp(14'd7);
    drive_cmd(1, 1, 14'd7, 8'hC2);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== expA) begin
      fails++; $display("FAIL err_addrA HTRANS=%h HADDR=%h required 2/%h", HTRANS, HADDR, expA);
    end
    @(negedge HCLK);
    tests++;
    if (HWDATA !== 32'hC1 || HTRANS !== 2'b10 || HADDR !== expB) begin
      fails++; $display("FAIL err_dataA HWDATA=%h HTRANS=%h HADDR=%h required C1/2/%h", HWDATA, HTRANS, HADDR, expB);
    end
    HRESP = 1'b1; HREADY = 1'b0;
    @(negedge HCLK);
    tests++;
    if (HTRANS !== 2'b00) begin fails++; $display("FAIL err_idle HTRANS=%h required 0", HTRANS); end
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESP = 1'b0;
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== expB || err_sticky !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL err_reissue HTRANS=%h HADDR=%h err=%b done=%b required 2/%h/1/0", HTRANS, HADDR, err_sticky, done, expB);
    end
    @(negedge HCLK);
    tests++;
    if (HWDATA !== 32'hC2 || HTRANS !== 2'b00) begin
      fails++; $display("FAIL err_dataB HWDATA=%h HTRANS=%h required C2/0", HWDATA, HTRANS);
    end
    @(negedge HCLK);
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL err_doneB got=%b required 1", done); end
    @(negedge HCLK);
    tests++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL err_count dones=%0d busy=%b required 1/0", done_cnt - d0, busy);
    end
    err_clr = 1'b1;
    @(negedge HCLK);
    err_clr = 1'b0;
    tests++;
    if (err_sticky !== 1'b0) begin fails++; $display("FAIL err_clear got=%b required 0", err_sticky); end
  endtask

`ifndef VGA_IMG_AUTOINC_EN
  task automatic test_offset0();
    int d0 = done_cnt;
    drive_cmd(1, 1, 14'd0, 8'h77);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (err_sticky !== 1'b1) begin fails++; $display("FAIL off0_err got=%b required 1", err_sticky); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (HTRANS !== 2'b00) begin fails++; $display("FAIL off0_idle[%0d] HTRANS=%h required 0", i, HTRANS); end
      @(negedge HCLK);
    end
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL off0_nodone dones=%0d required 0", done_cnt - d0); end
    drive_cmd(1, 1, 14'd0, 8'h78);
    err_clr = 1'b1;
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (err_sticky !== 1'b1) begin fails++; $display("FAIL off0_setwins got=%b required 1", err_sticky); end
    @(negedge HCLK);
    err_clr = 1'b0;
    tests++;
    if (err_sticky !== 1'b0) begin fails++; $display("FAIL off0_clear got=%b required 0", err_sticky); end
  endtask
`else
  task automatic test_autoinc();
    int g = 0;
    exp_ptr = 14'd1;
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1, 1, 14'd0, 8'h30);
      void'(img_exp(14'd0));
      @(negedge HCLK);
      drive_cmd(0, 0, 14'd0, 8'h00);
      @(negedge HCLK);
      tests++;
      if (HTRANS !== 2'b10 || HADDR !== 32'h5000_0000 + 32'((i + 1) * 4)) begin
        fails++; $display("FAIL autoinc[%0d] HTRANS=%h HADDR=%h required offset %0d", i, HTRANS, HADDR, i + 1);
      end
    end
    tests++;
    if (err_sticky !== 1'b0) begin fails++; $display("FAIL autoinc_err got=%b required 0", err_sticky); end
    while (exp_ptr != 14'd16383 && g < 20000) begin
      if (cmd_ready === 1'b1) begin drive_cmd(1, 1, 14'd0, 8'h31); void'(img_exp(14'd0)); end
      else drive_cmd(0, 0, 14'd0, 8'h00);
      @(negedge HCLK);
      g++;
    end
    drive_cmd(0, 0, 14'd0, 8'h00);
    wait_idle();
    drive_cmd(1, 1, 14'd0, 8'h32);
    @(negedge HCLK);
    drive_cmd(1, 1, 14'd0, 8'h33);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h5000_FFFC) begin
      fails++; $display("FAIL autoinc_last HADDR=%h required 5000FFFC", HADDR);
    end
    @(negedge HCLK);
    tests++;
    if (HTRANS !== 2'b10 || HADDR !== 32'h5000_0004) begin
      fails++; $display("FAIL autoinc_wrap HADDR=%h required 50000004", HADDR);
    end
    exp_ptr = 14'd2;
  endtask
`endif

  task automatic test_reset_mid();
    int d0;
    drive_cmd(1, 0, 14'd0, 8'h99);
    @(negedge HCLK);
    drive_cmd(0, 0, 14'd0, 8'h00);
    @(negedge HCLK);
    tests++;
    if (HTRANS !== 2'b10) begin fails++; $display("FAIL rstmid_pre HTRANS=%h required 2", HTRANS); end
    HRESETn = 1'b0;
    #1;
    tests++;
    if (HTRANS !== 2'b00 || busy !== 1'b0 || HWDATA !== 32'h0) begin
      fails++; $display("FAIL rstmid_abort HTRANS=%h busy=%b HWDATA=%h required 0/0/0", HTRANS, busy, HWDATA);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    exp_ptr = 14'd1;
    d0 = done_cnt;
    repeat (4) @(negedge HCLK);
    tests++;
    if (done_cnt !== d0 || HTRANS !== 2'b00 || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_quiet dones=%0d HTRANS=%h busy=%b required 0/0/0", done_cnt - d0, HTRANS, busy);
    end
  endtask

  initial begin
    test_reset();
    test_console();
    test_back_to_back();
    wait_idle();
    test_wait_states();
    wait_idle();
    test_fifo_full();
    wait_idle();
    test_error();
    wait_idle();
`ifndef VGA_IMG_AUTOINC_EN
    test_offset0();
`else
    test_autoinc();
`endif
    wait_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
